// File: rtl/instr_loader.sv
// Byte-stream instruction loader with LOAD/RUN mode control.
// Bytes arrive MSB first, are packed into instructions and written to consecutive addresses.
module instr_loader #(
  parameter int INSTR_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int TIMEOUT_CLKS = 2500000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_rx_dv,
  input  logic                   i_mode_switch,
  output logic                   o_run,
  output logic                   o_instr_we,
  output logic [ADDR_WIDTH-1:0]  o_instr_addr,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH:0]    o_count,
  output logic                   o_full,
  output logic                   o_overflow,
  output logic                   o_timeout_err
);

  localparam int BYTES = INSTR_WIDTH / 8;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES + 1) : 1;
  localparam int TW    = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IW-1:0]       BYTES_C  = IW'(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_WRITE, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   tmo_err_q, tmo_err_d;
  logic                   sw_q;
  logic                   tog_s;
  logic                   full_s;

  assign tog_s  = sw_q & ~i_mode_switch;
  assign full_s = (count_q == DEPTH_C);

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      sw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tmo_err_q  <= tmo_err_d;
      sw_q       <= i_mode_switch;
    end
  end

  // Next-state logic; a mode toggle always beats a same-cycle byte
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    count_d    = count_q;
    overflow_d = overflow_q;
    tmo_err_d  = tmo_err_q;
    case (state_q)
      S_IDLE: begin
        if (tog_s) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else if (i_rx_dv) begin
          shift_d[INSTR_WIDTH-1 -: 8] = i_rx_byte;
          idx_d   = IW'(1);
          state_d = (BYTES == 1) ? S_WRITE : S_ASSEMBLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ASSEMBLE: begin
        if (tog_s) begin
          state_d = S_RUN;
          idx_d   = '0;
        end else if (i_rx_dv) begin
          for (int b = 0; b < BYTES; b++) begin
            if (b == BYTES - 1 - int'(idx_q)) begin
              shift_d[b*8 +: 8] = i_rx_byte;
            end else begin
              shift_d[b*8 +: 8] = shift_q[b*8 +: 8];
            end
          end
          idx_d = idx_q + IW'(1);
          if (idx_q + IW'(1) == BYTES_C) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_ASSEMBLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          idx_d     = '0;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WRITE: begin
        if (full_s) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end
        idx_d   = '0;
        state_d = tog_s ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (tog_s) begin
          state_d    = S_IDLE;
          count_d    = '0;
          overflow_d = 1'b0;
          tmo_err_d  = 1'b0;
          idx_d      = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_run         = (state_q == S_RUN);
  assign o_instr_we    = (state_q == S_WRITE) && !full_s;
  assign o_instr_addr  = count_q[ADDR_WIDTH-1:0];
  assign o_instr       = shift_q;
  assign o_count       = count_q;
  assign o_full        = full_s;
  assign o_overflow    = overflow_q;
  assign o_timeout_err = tmo_err_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Byte-stream instruction loader and load/run mode controller for the FRANK6000 top level.
- Assembles UART bytes into INSTR_WIDTH-bit instructions (MSB byte first) and writes them into CPU instruction memory at consecutive addresses.
- Enforces memory depth, discards stale partial instructions on inter-byte timeout, and toggles load/run mode from a debounced switch.
- Sits between the UART byte receiver plus CPU-switch debouncer and the CPU instruction-write port.

Parameters:
INSTR_WIDTH, 16, instruction width in bits; multiple of 8, at least 8
ADDR_WIDTH, 8, instruction address width
DEPTH, 256, number of writable instruction slots; 1 to 2^ADDR_WIDTH
TIMEOUT_CLKS, 2500000, idle clocks between bytes of one instruction before the partial instruction is discarded; at least 2

Ports:
i_clk  in  1  master clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_byte  in  8  received UART byte
i_rx_dv  in  1  single-cycle strobe; i_rx_byte valid
i_mode_switch  in  1  debounced switch level; a falling edge requests a mode toggle
o_run  out  1  1 = RUN mode (CPU enabled), 0 = LOAD mode
o_instr_we  out  1  single-cycle instruction write strobe
o_instr_addr  out  ADDR_WIDTH  write address; valid while o_instr_we = 1
o_instr  out  INSTR_WIDTH  assembled instruction; valid while o_instr_we = 1
o_count  out  ADDR_WIDTH+1  number of instructions written since entering LOAD
o_full  out  1  o_count == DEPTH
o_overflow  out  1  sticky: a complete instruction was dropped because memory was full
o_timeout_err  out  1  sticky: a partial instruction was discarded on timeout

Behaviour:
- Reset (async, i_rst_n = 0):
  - State = IDLE (LOAD mode).
  - All outputs 0, byte index 0, timeout counter 0, switch edge register 0.
- Derived constant: BYTES = INSTR_WIDTH/8.
- Mode-toggle edge:
  - i_mode_switch is registered.
  - A toggle request is the registered value = 1 while the current i_mode_switch = 0.
- States: IDLE, ASSEMBLE, WRITE, RUN.
- IDLE:
  - On i_rx_dv, load the byte into the top byte of the shift register and set byte index = 1.
  - If BYTES == 1, go to WRITE; otherwise go to ASSEMBLE.
- ASSEMBLE:
  - On i_rx_dv, store the byte in the next lower byte position and increment the byte index.
  - When the byte index reaches BYTES, go to WRITE.
  - The timeout counter clears on every i_rx_dv and increments otherwise.
  - When the counter reaches TIMEOUT_CLKS-1:
    - discard the partial instruction and set o_timeout_err;
    - clear the byte index and go to IDLE.
- WRITE (exactly one cycle):
  - If o_full = 0: o_instr_we = 1, o_instr_addr = o_count[ADDR_WIDTH-1:0], o_instr = assembled word. o_count increments on the next edge.
  - If o_full = 1: no strobe; set o_overflow.
  - Next state is IDLE, or RUN if a toggle request is pending.
  - Latency: the final byte's i_rx_dv at cycle N gives o_instr_we at cycle N+1, and the incremented o_count at N+2.
- o_full: combinational compare of o_count with DEPTH; o_count saturates at DEPTH.
- Toggle request in IDLE or ASSEMBLE:
  - Discard any partial instruction and go to RUN; o_run = 1 from the next cycle.
  - An i_rx_dv in the same cycle is dropped; the toggle wins.
- Toggle request in WRITE: latch it as pending; the write completes, then the block enters RUN.
- RUN:
  - o_run = 1; i_rx_dv is ignored; o_instr_we stays 0.
  - A toggle request goes to IDLE, clears o_count, o_overflow, o_timeout_err and the byte index, and sets o_run = 0.
- No timeout counting outside ASSEMBLE; no wrap-around of addresses.
- Reset asserted mid-assembly or mid-write: immediate return to reset values; no strobe is emitted.

Test Plan:
1. INSTR_WIDTH=16: bytes 0xA1, 0x5C -> one o_instr_we pulse with o_instr_addr=0 and o_instr=0xA15C; o_count=1 two cycles after the 2nd strobe.
2. DEPTH=4: send 5 instructions -> 4 strobes at addresses 0-3; o_full=1; 5th dropped with no strobe; o_overflow=1, o_count=4.
3. TIMEOUT_CLKS=100: send 0x12, wait 100 clocks, then 0x34, 0x56 -> o_timeout_err=1; a single write of 0x3456 at address 0.
4. Toggle during ASSEMBLE after 1 byte -> o_run=1, no write; 2nd toggle -> o_run=0, o_count=0, errors cleared; a following 2-byte instruction writes to address 0.
5. Toggle edge in the same cycle as the final byte -> byte dropped, no write, o_run=1. Toggle during WRITE -> strobe still issued, then o_run=1.
6. Drop i_rst_n after byte 1 of 2, then release and send 0xBE, 0xEF -> no strobe during reset; outputs 0; next write is 0xBEEF at address 0.
